// File: rtl/hw_loop_pkg.sv
// Shared types, defaults and helpers for the hardware loop sequencer.
package hw_loop_pkg;

   localparam int PC_W_DEF  = 32;
   localparam int CNT_W_DEF = 8;
   localparam int DEPTH_DEF = 4;

   // One loop frame at the default widths; the stack builds the same layout
   // from its own parameters.
   typedef struct packed {
      logic [CNT_W_DEF-1:0] iter_left;
      logic [CNT_W_DEF-1:0] len;
      logic [CNT_W_DEF-1:0] len_left;
      logic [PC_W_DEF-1:0]  target;
      logic [PC_W_DEF-1:0]  ret;
   } frame_t;

   // Width needed to hold a frame count from 0 to d inclusive.
   function automatic int depth_w(input int d);
      return $clog2(d + 1);
   endfunction

endpackage

// File: rtl/hw_loop_stack.sv
// LIFO of loop frames: push a new frame, pop the top, rewrite the top's
// counters, and expose the top frame combinationally.
module hw_loop_stack
   import hw_loop_pkg::*;
#(
   parameter int PC_W  = PC_W_DEF,
   parameter int CNT_W = CNT_W_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       wr_top,
   input  logic [CNT_W-1:0]           wr_iter,
   input  logic [CNT_W-1:0]           wr_len_left,
   input  logic [CNT_W-1:0]           push_iter,
   input  logic [CNT_W-1:0]           push_len,
   input  logic [PC_W-1:0]            push_target,
   input  logic [PC_W-1:0]            push_ret,
   output logic [CNT_W-1:0]           top_iter,
   output logic [CNT_W-1:0]           top_len,
   output logic [CNT_W-1:0]           top_len_left,
   output logic [PC_W-1:0]            top_target,
   output logic [PC_W-1:0]            top_ret,
   output logic                       full,
   output logic                       empty,
   output logic [depth_w(DEPTH)-1:0]  count
);

   localparam int DW = depth_w(DEPTH);

   typedef struct packed {
      logic [CNT_W-1:0] iter_left;
      logic [CNT_W-1:0] len;
      logic [CNT_W-1:0] len_left;
      logic [PC_W-1:0]  target;
      logic [PC_W-1:0]  ret;
   } slot_t;

   logic [DW-1:0] count_reg;
   slot_t         slot_rd [DEPTH];
   slot_t         top_slot;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_slot
         slot_t slot_reg;

         // Slot gi is written by a push landing on it, or rewritten while it is the top.
         always_ff @(posedge clk) begin
            if (push && count_reg == DW'(gi)) begin
               slot_reg <= '{push_iter, push_len, push_len, push_target, push_ret};
            end else if (wr_top && count_reg == DW'(gi + 1)) begin
               slot_reg.iter_left <= wr_iter;
               slot_reg.len_left  <= wr_len_left;
            end
         end

         assign slot_rd[gi] = slot_reg;
      end
   endgenerate

   // Occupancy: a push and a top rewrite may share a cycle; push never coincides with pop.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count_reg <= '0;
      end else if (push) begin
         count_reg <= count_reg + DW'(1);
      end else if (pop) begin
         count_reg <= count_reg - DW'(1);
      end
   end

   // Select the top frame; reads as zero when the stack is empty.
   always_comb begin
      top_slot = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (count_reg == DW'(i + 1)) top_slot = slot_rd[i];
      end
   end

   assign top_iter     = top_slot.iter_left;
   assign top_len      = top_slot.len;
   assign top_len_left = top_slot.len_left;
   assign top_target   = top_slot.target;
   assign top_ret      = top_slot.ret;
   assign full         = (count_reg == DW'(DEPTH));
   assign empty        = (count_reg == '0);
   assign count        = count_reg;

endmodule

// File: rtl/hw_loop_ctrl.sv
// Zero-overhead nested loop sequencer: overrides the core's next PC on loop
// entry, body wrap and loop exit, and records rejected loop starts.
module hw_loop_ctrl
   import hw_loop_pkg::*;
#(
   parameter int PC_W  = PC_W_DEF,
   parameter int CNT_W = CNT_W_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       step,
   input  logic                       start,
   input  logic [CNT_W-1:0]           start_iter,
   input  logic [CNT_W-1:0]           start_len,
   input  logic [PC_W-1:0]            start_target,
   input  logic [PC_W-1:0]            start_ret,
   input  logic                       abort,
   input  logic [PC_W-1:0]            pc_core,
   output logic [PC_W-1:0]            pc_next,
   output logic                       redirect,
   output logic                       active,
   output logic [depth_w(DEPTH)-1:0]  depth,
   output logic                       err_ovf,
   output logic                       err_nest
);

   logic             clear, push, pop, wr_top;
   logic [CNT_W-1:0] wr_iter, wr_len_left;
   logic [CNT_W-1:0] top_iter, top_len, top_len_left;
   logic [PC_W-1:0]  top_target, top_ret;
   logic             full, empty;
   logic             set_ovf, set_nest;
   logic             count_step;
   logic [PC_W-1:0]  eff_pc;
   logic             err_ovf_reg, err_nest_reg;

   hw_loop_stack #(.PC_W(PC_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) u_stack (
      .clk          (clk),
      .rst          (rst),
      .clear        (clear),
      .push         (push),
      .pop          (pop),
      .wr_top       (wr_top),
      .wr_iter      (wr_iter),
      .wr_len_left  (wr_len_left),
      .push_iter    (start_iter),
      .push_len     (start_len),
      .push_target  (start_target),
      .push_ret     (start_ret),
      .top_iter     (top_iter),
      .top_len      (top_len),
      .top_len_left (top_len_left),
      .top_target   (top_target),
      .top_ret      (top_ret),
      .full         (full),
      .empty        (empty),
      .count        (depth)
   );

   // Next-PC decision: start handling first, then the top frame counts the instruction.
   always_comb begin
      pc_next     = pc_core;
      redirect    = 1'b0;
      clear       = 1'b0;
      push        = 1'b0;
      pop         = 1'b0;
      wr_top      = 1'b0;
      wr_iter     = top_iter;
      wr_len_left = top_len_left;
      set_ovf     = 1'b0;
      set_nest    = 1'b0;
      count_step  = 1'b0;
      eff_pc      = pc_core;
      if (rst) begin
         clear = 1'b0;
      end else if (abort) begin
         clear = 1'b1;
      end else if (step) begin
         count_step = 1'b1;
         if (start) begin
            if (start_iter == '0 || start_len == '0) begin
               // Empty loop: jump straight past it, counted as a plain instruction.
               eff_pc   = start_ret;
               redirect = 1'b1;
            end else if (full) begin
               set_ovf  = 1'b1;
               eff_pc   = start_ret;
               redirect = 1'b1;
            end else if (!empty && top_len_left == CNT_W'(1)) begin
               // A loop cannot start on the last instruction of its enclosing body.
               set_nest = 1'b1;
               eff_pc   = start_ret;
               redirect = 1'b1;
            end else begin
               count_step  = 1'b0;
               push        = 1'b1;
               wr_top      = !empty;
               wr_len_left = top_len_left - CNT_W'(1);
               pc_next     = start_target;
               redirect    = 1'b1;
            end
         end
         if (count_step) begin
            pc_next = eff_pc;
            if (!empty) begin
               if (top_len_left > CNT_W'(1)) begin
                  wr_top      = 1'b1;
                  wr_len_left = top_len_left - CNT_W'(1);
               end else if (top_iter > CNT_W'(1)) begin
                  wr_top      = 1'b1;
                  wr_iter     = top_iter - CNT_W'(1);
                  wr_len_left = top_len;
                  pc_next     = top_target;
                  redirect    = 1'b1;
               end else begin
                  pop      = 1'b1;
                  pc_next  = top_ret;
                  redirect = 1'b1;
               end
            end
         end
      end
   end

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_ovf_reg  <= 1'b0;
         err_nest_reg <= 1'b0;
      end else begin
         if (set_ovf)  err_ovf_reg  <= 1'b1;
         if (set_nest) err_nest_reg <= 1'b1;
      end
   end

   assign err_ovf  = err_ovf_reg;
   assign err_nest = err_nest_reg;
   assign active   = !empty;

endmodule
